// File: rtl/pwm_capture.sv
// Single-channel PWM capture: synchronizes and deglitches pwm_in, then measures period and
// high time in timebase ticks and hands each measurement out on a valid/ready register.
module pwm_capture #(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned FILTER_LENGTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     timebase,
  input  logic                     pwm_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [COUNTER_WIDTH-1:0] m_period,
  output logic [COUNTER_WIDTH-1:0] m_high,
  output logic                     timeout,
  output logic                     overrun,
  output logic                     filtered_level
);

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  localparam logic [7:0]               FiltLast = 8'(FILTER_LENGTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] CntMax   = '1;

  state_e                   state_q, state_d;
  logic [1:0]               sync_q;
  logic                     filt_q, filt_prev_q;
  logic [7:0]               fcnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] high_q, high_d;
  logic [COUNTER_WIDTH-1:0] period_out_q, high_out_q;
  logic                     valid_q, overrun_q, timeout_q, en_prev_q;
  logic                     emit, timeout_d;
  logic                     rise, fall, overflow;
  logic [COUNTER_WIDTH-1:0] tick, cnt_inc;

  // Synchronizer plus glitch filter: the level follows only after FILTER_LENGTH stable cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], pwm_in};
      filt_prev_q <= filt_q;
      if (sync_q[1] != filt_q) begin
        if (fcnt_q == FiltLast) begin
          filt_q <= sync_q[1];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 8'd1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  assign rise     = filt_q & ~filt_prev_q;
  assign fall     = ~filt_q & filt_prev_q;
  assign tick     = {{(COUNTER_WIDTH - 1){1'b0}}, timebase};
  assign cnt_inc  = cnt_q + tick;
  assign overflow = (cnt_q == CntMax) && timebase;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_d    = high_q;
    emit      = 1'b0;
    timeout_d = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = tick;
            state_d = StHigh;
          end
        end
        StHigh, StLow: begin
          // Overflow outranks any edge seen on the same cycle.
          if (overflow) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = StArm;
          end else if (state_q == StHigh && fall) begin
            high_d  = cnt_q;
            cnt_d   = cnt_inc;
            state_d = StLow;
          end else if (state_q == StLow && rise) begin
            emit    = 1'b1;
            cnt_d   = tick;
            state_d = StHigh;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      en_prev_q    <= 1'b0;
      period_out_q <= '0;
      high_out_q   <= '0;
    end else begin
      timeout_q <= timeout_d;
      en_prev_q <= enable;
      if (enable && !en_prev_q) begin
        overrun_q <= 1'b0;
      end
      if (emit) begin
        period_out_q <= cnt_q;
        high_out_q   <= high_q;
        valid_q      <= 1'b1;
        if (valid_q && !m_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m_valid        = valid_q;
  assign m_period       = period_out_q;
  assign m_high         = high_out_q;
  assign timeout        = timeout_q;
  assign overrun        = overrun_q;
  assign filtered_level = filt_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of PWM waveforms feeding a measurement scoreboard, followed by
// hand-written timeout, backpressure, reset and enable sequences.
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int FL = 4;

  logic          clock = 1'b0;
  logic          reset, enable, timebase, pwm_in, m_ready;
  logic          m_valid, timeout, overrun, filtered_level;
  logic [CW-1:0] m_period, m_high;

  pwm_capture #(.COUNTER_WIDTH(CW), .FILTER_LENGTH(FL)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .timebase       (timebase),
    .pwm_in         (pwm_in),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_period       (m_period),
    .m_high         (m_high),
    .timeout        (timeout),
    .overrun        (overrun),
    .filtered_level (filtered_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    int period; int high; int n; int div; int glen; int gat; int nexp;
    int ep[3]; int eh[3];
  } vec_t;
  typedef struct { int p; int h; } meas_t;

  meas_t sb[$];
  meas_t got;
  vec_t  tbl[6];
  int    checks = 0;
  int    errors = 0;
  int    tb_div = 1;
  int    cyc = 0;
  bit    mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic vec_t mk(int period, int high, int n, int div, int glen, int gat, int nexp,
                              int p0, int h0, int p1, int h1, int p2, int h2);
    vec_t v;
    v.period = period; v.high = high; v.n = n; v.div = div;
    v.glen = glen; v.gat = gat; v.nexp = nexp;
    v.ep[0] = p0; v.ep[1] = p1; v.ep[2] = p2;
    v.eh[0] = h0; v.eh[1] = h1; v.eh[2] = h2;
    return v;
  endfunction

  // Each accepted rise after the first completes a period; its expectation is queued on drive.
  task automatic rise_push(inout int k, input vec_t v);
    meas_t m;
    if (k >= 1 && k - 1 < v.nexp) begin
      m.p = v.ep[k-1];
      m.h = v.eh[k-1];
      sb.push_back(m);
    end
    k++;
  endtask

  task automatic run_wave(input vec_t v);
    int k = 0;
    for (int p = 0; p < v.n; p++) begin
      pwm_in = 1'b1;
      rise_push(k, v);
      step(v.high);
      pwm_in = 1'b0;
      if (p == 1 && v.glen > 0) begin
        step(v.gat - v.high);
        pwm_in = 1'b1;
        if (v.glen >= FL) rise_push(k, v);
        step(v.glen);
        pwm_in = 1'b0;
        step(v.period - v.gat - v.glen);
      end else begin
        step(v.period - v.high);
      end
    end
  endtask

  task automatic restart(input int div);
    enable = 1'b0;
    pwm_in = 1'b0;
    step(12);
    tb_div = div;
    enable = 1'b1;
    step(3);
  endtask

  initial begin
    timebase = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      timebase = (cyc % tb_div == 0);
    end
  end

  always @(negedge clock) begin
    if (mon_en && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas: got period %0d high %0d expected none", m_period, m_high);
      end else begin
        got = sb.pop_front();
        check("meas_period", 32'(m_period), 32'(got.p));
        check("meas_high", 32'(m_high), 32'(got.h));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int highs[4];
    highs = '{20, 50, 20, 50};
    tbl[0] = mk(100, 30, 4, 1, 0, 0, 3, 100, 30, 100, 30, 100, 30);
    tbl[1] = mk(100, 40, 3, 4, 0, 0, 2, 25, 10, 25, 10, 0, 0);
    tbl[2] = mk(100, 30, 3, 1, 3, 60, 2, 100, 30, 100, 30, 0, 0);
    tbl[3] = mk(100, 30, 3, 1, 4, 60, 3, 100, 30, 60, 30, 40, 4);
    tbl[4] = mk(60, 20, 3, 2, 0, 0, 2, 30, 10, 30, 10, 0, 0);
    tbl[5] = mk(37, 11, 4, 1, 0, 0, 3, 37, 11, 37, 11, 37, 11);

    reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; m_ready = 1'b1;
    step(3);
    check("rst_valid", m_valid, 0);
    check("rst_period", 32'(m_period), 0);
    check("rst_high", 32'(m_high), 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", overrun, 0);
    check("rst_level", filtered_level, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      restart(tbl[i].div);
      run_wave(tbl[i]);
      step(20);
      check("sb_drained", sb.size(), 0);
      check("no_overrun", overrun, 0);
    end

    // Timeout with an 8-bit counter: single rise, then input held low.
    restart(1);
    pwm_in = 1'b1;
    step(5);
    check("latency_before", filtered_level, 0);
    step(1);
    check("latency_at", filtered_level, 1);
    step(4);
    pwm_in = 1'b0;
    t = 10;
    while (t < 400 && timeout !== 1'b1) begin
      step(1);
      t++;
    end
    check("timeout_at", t, 262);
    step(1);
    check("timeout_pulse", timeout, 0);
    run_wave(mk(100, 30, 3, 1, 0, 0, 2, 100, 30, 100, 30, 0, 0));
    step(20);
    check("rearm_drained", sb.size(), 0);

    // Backpressure: three measurements land while m_ready stays low.
    mon_en = 1'b0;
    m_ready = 1'b0;
    restart(1);
    for (int i = 0; i < 4; i++) begin
      pwm_in = 1'b1;
      step(highs[i]);
      pwm_in = 1'b0;
      step(100 - highs[i]);
    end
    check("bp_valid", m_valid, 1);
    check("bp_period", 32'(m_period), 100);
    check("bp_high", 32'(m_high), 20);
    check("bp_overrun", overrun, 1);
    step(5);
    check("bp_hold", 32'(m_high), 20);
    m_ready = 1'b1;
    step(1);
    check("bp_xfer", m_valid, 0);
    check("bp_ovr_sticky", overrun, 1);
    step(3);
    check("bp_stays_low", m_valid, 0);
    enable = 1'b0;
    step(1);
    check("bp_ovr_en_low", overrun, 1);
    enable = 1'b1;
    step(1);
    check("bp_ovr_clear", overrun, 0);

    // Reset in the middle of a high phase with a pending, overrun measurement.
    m_ready = 1'b0;
    step(2);
    for (int i = 0; i < 2; i++) begin
      pwm_in = 1'b1;
      step(30);
      pwm_in = 1'b0;
      step(70);
    end
    pwm_in = 1'b1;
    step(20);
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    #3;
    reset = 1'b1;
    pwm_in = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_period", 32'(m_period), 0);
    check("arst_high", 32'(m_high), 0);
    check("arst_overrun", overrun, 0);
    check("arst_level", filtered_level, 0);
    check("arst_timeout", timeout, 0);
    step(2);
    reset = 1'b0;
    m_ready = 1'b1;
    mon_en = 1'b1;
    step(2);
    run_wave(mk(100, 30, 3, 1, 0, 0, 2, 100, 30, 100, 30, 0, 0));
    step(20);
    check("post_rst_drained", sb.size(), 0);

    // Dropping enable keeps a pending measurement until it is accepted.
    mon_en = 1'b0;
    m_ready = 1'b0;
    restart(1);
    pwm_in = 1'b1;
    step(45);
    pwm_in = 1'b0;
    step(55);
    pwm_in = 1'b1;
    step(10);
    check("en_pending", m_valid, 1);
    enable = 1'b0;
    step(20);
    pwm_in = 1'b0;
    step(70);
    pwm_in = 1'b1;
    step(30);
    pwm_in = 1'b0;
    step(20);
    check("en_hold_valid", m_valid, 1);
    check("en_hold_period", 32'(m_period), 100);
    check("en_hold_high", 32'(m_high), 45);
    m_ready = 1'b1;
    step(1);
    check("en_xfer", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
